// File: rtl/hack_boot_ctrl.sv
// Bring-up sequencer for the HACK computer: zeroes data RAM, streams a program
// into instruction ROM, then releases the CPU. A start pulse in RUN repeats it.
module hack_boot_ctrl #(
    parameter int ROM_AW    = 15,
    parameter int RAM_AW    = 14,
    parameter bit CLEAR_RAM = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              rom_we,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [15:0]       rom_data,
    output logic              ram_sel,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [15:0]       ram_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              error,
    output logic [ROM_AW:0]   word_count,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam state_t INIT_STATE = CLEAR_RAM ? S_CLEAR : S_LOAD;

    state_t            state, state_next;
    logic [RAM_AW-1:0] clr_addr;
    logic [ROM_AW-1:0] rom_ptr;
    logic              accept;
    logic              clr_done;
    logic              ptr_full;

    // Word handshake: a word transfers on a rising edge where in_valid and
    // in_ready are both 1; in_ready never depends on in_valid, and the ROM
    // write happens at that same edge.
    assign accept   = in_valid & in_ready;
    assign clr_done = (clr_addr == {RAM_AW{1'b1}});
    assign ptr_full = (rom_ptr == {ROM_AW{1'b1}});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= INIT_STATE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_CLEAR: if (clr_done) state_next = S_LOAD;
            S_LOAD:  if (accept && (in_last || ptr_full)) state_next = S_RUN;
            S_RUN:   if (start) state_next = INIT_STATE;
            default: state_next = INIT_STATE;
        endcase
    end

    // Strobes are gated by reset so they drop the moment reset is asserted.
    always_comb begin
        in_ready  = 1'b0;
        ram_sel   = 1'b0;
        ram_we    = 1'b0;
        cpu_reset = (state != S_RUN);
        case (state)
            S_CLEAR: begin
                ram_sel = 1'b1;
                ram_we  = reset;
            end
            S_LOAD:  in_ready = reset;
            default: ;
        endcase
        busy      = cpu_reset;
        rom_we    = in_valid & in_ready;
        rom_addr  = rom_ptr;
        rom_data  = in_data;
        ram_addr  = clr_addr;
        ram_data  = 16'h0000;
        dbg_state = state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_addr   <= '0;
            rom_ptr    <= '0;
            word_count <= '0;
            error      <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_done) rom_ptr <= '0;
                end
                S_LOAD: if (accept) begin
                    // The pointer saturates at the top of ROM instead of wrapping.
                    if (!ptr_full) rom_ptr <= rom_ptr + 1'b1;
                    if (in_last) begin
                        word_count <= {1'b0, rom_ptr} + 1'b1;
                    end else if (ptr_full) begin
                        error      <= 1'b1;
                        word_count <= {1'b1, {ROM_AW{1'b0}}};
                    end
                end
                S_RUN: if (start) begin
                    error    <= 1'b0;
                    rom_ptr  <= '0;
                    clr_addr <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hack_boot_ctrl.sv
// Directed bench for hack_boot_ctrl: RAM clear, program loads, stalls, overflow,
// restart from RUN and asynchronous reset mid-load, with queued expected writes.
module tb_hack_boot_ctrl;

    localparam int ROM_AW = 3;
    localparam int RAM_AW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [15:0]       in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              rom_we;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              ram_sel;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [15:0]       ram_data;
    logic              cpu_reset;
    logic              busy;
    logic              error;
    logic [ROM_AW:0]   word_count;
    logic [1:0]        dbg_state;

    hack_boot_ctrl #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .CLEAR_RAM(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .rom_we(rom_we), .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_sel(ram_sel), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
        .cpu_reset(cpu_reset), .busy(busy), .error(error),
        .word_count(word_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    logic [RAM_AW-1:0]    ram_q[$];
    logic [ROM_AW+15:0]   rom_q[$];
    int                   checks = 0;
    int                   passed = 0;
    int                   ram_writes = 0;
    int                   rom_writes = 0;
    logic [ROM_AW-1:0]    exp_addr;
    logic [31:0]          mon_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard side: every write strobe seen at a negedge pops one expectation.
    always @(negedge clk) begin
        if (ram_we) begin
            ram_writes++;
            mon_exp = (ram_q.size() > 0) ? 32'(ram_q.pop_front()) : 32'hDEAD;
            check("ram_addr", 32'(ram_addr), mon_exp);
            check("ram_data", 32'(ram_data), 32'h0);
        end
        if (rom_we) begin
            rom_writes++;
            mon_exp = (rom_q.size() > 0) ? 32'(rom_q.pop_front()) : 32'hDEAD;
            check("rom_write", 32'({rom_addr, rom_data}), mon_exp);
        end
    end

    task automatic push_clear();
        for (int i = 0; i < (1 << RAM_AW); i++) ram_q.push_back(RAM_AW'(i));
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(in_ready), 32'h1);
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'h1);
        check({tag, "_ram_q_left"}, ram_q.size(), 0);
        exp_addr   = '0;
        rom_writes = 0;
    endtask

    task automatic send(input logic [15:0] d, input logic last, input logic v);
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = d;
        in_last  = last;
        if (v) begin
            rom_q.push_back({exp_addr, d});
            exp_addr = exp_addr + 1'b1;
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b1; in_data = 16'h1234; in_last = 1'b0;
        exp_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_cpu_reset", 32'(cpu_reset), 32'h1);
        check("rst_busy", 32'(busy), 32'h1);
        check("rst_ram_sel", 32'(ram_sel), 32'h1);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_rom_we", 32'(rom_we), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_word_count", 32'(word_count), 32'h0);

        // Reset release and RAM clear
        push_clear();
        ram_writes = 0;
        @(posedge clk);
        #1 reset = 1'b1; in_valid = 1'b0;
        wait_ready("clear1");
        check("clear1_count", ram_writes, 16);

        // Three-word program
        send(16'h0002, 1'b0, 1'b1);
        send(16'hEC10, 1'b0, 1'b1);
        send(16'h0000, 1'b1, 1'b1);
        send(16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        check("load3_cpu_reset", 32'(cpu_reset), 32'h0);
        check("load3_busy", 32'(busy), 32'h0);
        check("load3_word_count", 32'(word_count), 32'h3);
        check("load3_writes", rom_writes, 3);
        check("load3_state", 32'(dbg_state), 32'h2);
        // in_valid in RUN is not consumed
        in_valid = 1'b1;
        #1;
        check("run_in_ready", 32'(in_ready), 32'h0);
        check("run_rom_we", 32'(rom_we), 32'h0);
        in_valid = 1'b0;

        // Restart, then a stalled stream with a start pulse mid-load
        push_clear();
        pulse_start();
        @(negedge clk);
        check("restart_cpu_reset", 32'(cpu_reset), 32'h1);
        check("restart_ram_sel", 32'(ram_sel), 32'h1);
        check("restart_wc_hold", 32'(word_count), 32'h3);
        wait_ready("clear2");
        send(16'h1111, 1'b0, 1'b1);
        send(16'hFFFF, 1'b0, 1'b0);
        #1 start = 1'b1;
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'h1);
        send(16'hFFFF, 1'b0, 1'b0);
        #1 start = 1'b0;
        @(negedge clk);
        check("start_in_load_ignored", 32'(dbg_state), 32'h1);
        send(16'h2222, 1'b0, 1'b1);
        send(16'h3333, 1'b1, 1'b1);
        send(16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        check("stall_writes", rom_writes, 3);
        check("stall_word_count", 32'(word_count), 32'h3);
        check("stall_cpu_reset", 32'(cpu_reset), 32'h0);

        // Overflow: eight words with no last marker
        push_clear();
        pulse_start();
        wait_ready("clear3");
        for (int i = 0; i < 8; i++) send(16'(32'hA000 + $urandom_range(0, 4095)), 1'b0, 1'b1);
        send(16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        check("ovf_error", 32'(error), 32'h1);
        check("ovf_word_count", 32'(word_count), 32'h8);
        check("ovf_state", 32'(dbg_state), 32'h2);
        check("ovf_writes", rom_writes, 8);
        @(posedge clk);
        #1 in_valid = 1'b1;
        @(negedge clk);
        check("ovf_ninth_ready", 32'(in_ready), 32'h0);
        check("ovf_ninth_we", 32'(rom_we), 32'h0);
        in_valid = 1'b0;

        // Restart clears error; then async reset after two words
        push_clear();
        pulse_start();
        @(negedge clk);
        check("restart_error_clr", 32'(error), 32'h0);
        check("restart2_cpu_reset", 32'(cpu_reset), 32'h1);
        wait_ready("clear4");
        send(16'h0101, 1'b0, 1'b1);
        send(16'h0202, 1'b0, 1'b1);
        send(16'h0303, 1'b0, 1'b1);
        rom_q.delete();
        #2 reset = 1'b0;
        #1;
        check("async_cpu_reset", 32'(cpu_reset), 32'h1);
        check("async_ram_sel", 32'(ram_sel), 32'h1);
        check("async_in_ready", 32'(in_ready), 32'h0);
        check("async_rom_we", 32'(rom_we), 32'h0);
        check("async_word_count", 32'(word_count), 32'h0);
        check("async_state", 32'(dbg_state), 32'h0);
        in_valid = 1'b0;
        push_clear();
        ram_writes = 0;
        @(posedge clk);
        #1 reset = 1'b1;
        wait_ready("clear5");
        check("clear5_count", ram_writes, 16);
        check("rom_q_left", rom_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/hack_boot_ctrl.md
# hack_boot_ctrl

Bring-up sequencer for the HACK computer. It holds the CPU in reset while it zeroes data RAM, then streams a program into instruction ROM over a valid/ready word interface, and then releases the CPU to run. While active it owns the RAM write port through a select line; the top level muxes it against the CPU's `addressM`/`outM`/`writeM`. A `start` pulse from RUN repeats the whole sequence, so a new program can be loaded without a board reset.

## Interface

Parameters:
- `ROM_AW`, default 15: instruction ROM address width; ROM depth is 2^ROM_AW words.
- `RAM_AW`, default 14: data RAM address width; the clear phase covers 2^RAM_AW words.
- `CLEAR_RAM`, default 1: 1 runs the CLEAR phase; 0 skips it (reset and `start` go straight to LOAD).

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset (asserted when 0).
- `start`  input  1  single-cycle request to reload; honoured only in RUN.
- `in_data`  input  16  program word.
- `in_valid`  input  1  `in_data` is valid.
- `in_last`  input  1  qualifies the final word of the program.
- `in_ready`  output  1  controller accepts a word this cycle.
- `rom_we`  output  1  ROM write strobe.
- `rom_addr`  output  ROM_AW  ROM write address.
- `rom_data`  output  16  ROM write data.
- `ram_sel`  output  1  1 = controller drives RAM port; 0 = CPU drives it.
- `ram_we`  output  1  RAM write strobe (valid only when `ram_sel`=1).
- `ram_addr`  output  RAM_AW  RAM clear address.
- `ram_data`  output  16  constant 16'h0000.
- `cpu_reset`  output  1  active-high reset to the CPU.
- `busy`  output  1  state is not RUN.
- `error`  output  1  sticky ROM overflow flag.
- `word_count`  output  ROM_AW+1  number of words written by the last load.

## Operation

- State register with three states: CLEAR, LOAD, RUN. Outputs decode from the state register and counters.
- Reset (`reset`=0), applied at any time, including mid-phase:
  - state = CLEAR if `CLEAR_RAM`=1, else LOAD.
  - `clr_addr`=0, `rom_ptr`=0, `word_count`=0, `error`=0.
  - Outputs during reset: `cpu_reset`=1, `busy`=1, `ram_sel`=`CLEAR_RAM`, `in_ready`=0, `rom_we`=0.
- CLEAR:
  - `ram_sel`=1, `ram_we`=1, `ram_addr`=`clr_addr`.
  - `clr_addr` increments every cycle.
  - At `clr_addr`=2^RAM_AW−1 the write still occurs; next state is LOAD, `clr_addr` returns to 0, `rom_ptr` is cleared.
- LOAD:
  - `in_ready`=1, `ram_sel`=0.
  - `rom_we` = `in_valid` (combinational); `rom_addr`=`rom_ptr`; `rom_data`=`in_data`.
  - Each accepted word (`in_valid`&`in_ready`) increments `rom_ptr`.
  - If the accepted word has `in_last`=1: `word_count` ← `rom_ptr`+1, next state RUN.
  - If a word is accepted at `rom_ptr`=2^ROM_AW−1 with `in_last`=0: the word is written, `error` ← 1, `word_count` ← 2^ROM_AW, next state RUN. The pointer never wraps.
  - `in_valid`=0 stalls indefinitely; there is no timeout.
- RUN:
  - `cpu_reset`=0, `busy`=0, `ram_sel`=0, `in_ready`=0, `rom_we`=0.
  - `start`=1 → CLEAR (or LOAD if `CLEAR_RAM`=0). This clears `error`; `word_count` holds until the next load completes.
- `start` outside RUN is ignored. `in_valid` outside LOAD is ignored, and no word is consumed.
- `cpu_reset` = (state ≠ RUN). `busy` = `cpu_reset`.

## Timing

- Clear phase: exactly 2^RAM_AW cycles.
- Load phase: one word per cycle at full throughput.
- `cpu_reset` falls in the first cycle in RUN, one edge after the `in_last` handshake. The CPU fetches ROM[0] on the following edge.
- ROM write latency is 0: the write occurs at the same edge as the handshake.
- `start` sampled high in RUN → `cpu_reset`=1 and `ram_sel`=1 from the next cycle.
- Reset deassertion is synchronised externally to `clk`; no internal synchroniser.

## Test plan

- **Reset and clear.** `RAM_AW`=4: release reset → `ram_we`=1 for exactly 16 cycles with `ram_addr` 0..15, then `in_ready`=1; `cpu_reset`=1 throughout.
- **Three-word load.** Words 16'h0002, 16'hEC10, 16'h0000 with `in_last` on the third → ROM writes at addresses 0, 1, 2. `word_count`=3; `cpu_reset`=0 on the cycle after the third handshake.
- **Stalled stream.** Toggle `in_valid` 1,0,0,1,1(last) → exactly 3 ROM writes at addresses 0..2; no write in stalled cycles.
- **Overflow.** `ROM_AW`=3, send 8 words with no `in_last` → 8 writes (0..7), `error`=1, `word_count`=8, state RUN. A ninth `in_valid` is not accepted.
- **Restart from RUN.** Pulse `start` in RUN → `cpu_reset`=1 next cycle, clear repeats, `error` cleared. `start` pulsed mid-LOAD has no effect.
- **Async reset mid-LOAD.** After 2 words, drop `reset` → outputs go to reset values immediately, without waiting for a clock edge. On release, clear restarts from address 0.
